// File: rtl/stage_ex_md.sv
// Execute stage: operand forwarding/select, single-cycle ALU and an iterative RV32M unit.
// Define RISCV_MD_DIV_EN to build the divider; without it DIV/DIVU/REM/REMU raise ex_illegal.
module stage_ex_md #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_W     = $clog2(REG_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ID_EX_valid,
    input  logic                 EX_flush,
    input  logic [1:0]           forwardA,
    input  logic [1:0]           forwardB,
    input  logic [REG_WIDTH-1:0] ID_EX_pc,
    input  logic [REG_WIDTH-1:0] ID_EX_data_out_1,
    input  logic [REG_WIDTH-1:0] ID_EX_data_out_2,
    input  logic [REG_WIDTH-1:0] ID_EX_imm_out,
    input  logic [REG_WIDTH-1:0] WB_data,
    input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
    input  logic [2:0]           ID_EX_alu_sel,
    input  logic                 ID_EX_ASel,
    input  logic                 ID_EX_BSel,
    input  logic                 ID_EX_md_en,
    input  logic [2:0]           ID_EX_md_op,
    output logic [REG_WIDTH-1:0] alu_out,
    output logic [REG_WIDTH-1:0] dataB,
    output logic                 ex_stall,
    output logic                 ex_illegal
);
    localparam int unsigned W    = REG_WIDTH;
    localparam int unsigned SH_W = $clog2(REG_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0] acc;
    logic [W-1:0]   a_mag, b_mag, result;
    logic [1:0]     op_q;
    logic           sgn_a, sgn_b;

    logic [W-1:0]   fwd_a, fwd_b, op_a, op_b, alu_res, abs_a, abs_b;
    logic           sgn_a_in, sgn_b_in, md_go;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next, prod;

    // Forwarding muxes: 00 ID/EX, 01 WB, 10 EX/MEM, 11 zero
    always_comb begin
        case (forwardA)
            2'b00:   fwd_a = ID_EX_data_out_1;
            2'b01:   fwd_a = WB_data;
            2'b10:   fwd_a = EX_MEM_alu_out;
            default: fwd_a = '0;
        endcase
        case (forwardB)
            2'b00:   fwd_b = ID_EX_data_out_2;
            2'b01:   fwd_b = WB_data;
            2'b10:   fwd_b = EX_MEM_alu_out;
            default: fwd_b = '0;
        endcase
    end

    assign op_a  = ID_EX_ASel ? ID_EX_pc : fwd_a;
    assign op_b  = ID_EX_BSel ? ID_EX_imm_out : fwd_b;
    assign dataB = fwd_b;

    // ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra
    always_comb begin
        case (ID_EX_alu_sel)
            3'b000:  alu_res = op_a + op_b;
            3'b001:  alu_res = op_a - op_b;
            3'b010:  alu_res = op_a & op_b;
            3'b011:  alu_res = op_a | op_b;
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = op_a << op_b[SH_W-1:0];
            3'b110:  alu_res = op_a >> op_b[SH_W-1:0];
            default: alu_res = W'($signed(op_a) >>> op_b[SH_W-1:0]);
        endcase
    end

    // Operand signedness per M-op; MULHSU keeps rs2 unsigned
    always_comb begin
        sgn_a_in = fwd_a[W-1] & (ID_EX_md_op inside {3'b001, 3'b010, 3'b100, 3'b110});
        sgn_b_in = fwd_b[W-1] & (ID_EX_md_op inside {3'b001, 3'b100, 3'b110});
        abs_a    = sgn_a_in ? -fwd_a : fwd_a;
        abs_b    = sgn_b_in ? -fwd_b : fwd_b;
    end

    // Shift-add step: add multiplicand on the low multiplier bit, then shift right
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
        mul_next = {mul_sum, acc[W-1:1]};
        prod     = (sgn_a ^ sgn_b) ? -mul_next : mul_next;
    end

`ifdef RISCV_MD_DIV_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] quo, rem, quo_next, rem_next, q_fin, r_fin, early_res;
    logic [W:0]   div_shift, div_trial;
    logic         div_zero, div_ovf;

    // Restoring division step plus the RISC-V defined early-out results
    always_comb begin
        div_shift = {rem, quo[W-1]};
        div_trial = div_shift - {1'b0, b_mag};
        if (div_trial[W]) begin
            rem_next = div_shift[W-1:0];
            quo_next = {quo[W-2:0], 1'b0};
        end else begin
            rem_next = div_trial[W-1:0];
            quo_next = {quo[W-2:0], 1'b1};
        end
        q_fin    = (sgn_a ^ sgn_b) ? -quo_next : quo_next;
        r_fin    = sgn_a ? -rem_next : rem_next;
        div_zero = (fwd_b == '0);
        div_ovf  = !ID_EX_md_op[0] && (fwd_a == MOST_NEG) && (fwd_b == '1);
        if (ID_EX_md_op[1]) early_res = div_zero ? fwd_a : '0;
        else                early_res = div_zero ? '1 : fwd_a;
    end

    assign md_go      = ID_EX_md_en && ID_EX_valid && !EX_flush && (state == S_IDLE);
    assign ex_illegal = 1'b0;
`else
    assign md_go      = ID_EX_md_en && ID_EX_valid && !EX_flush && (state == S_IDLE)
                        && !ID_EX_md_op[2];
    assign ex_illegal = !reset && ID_EX_valid && ID_EX_md_en && ID_EX_md_op[2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            op_q   <= '0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
`ifdef RISCV_MD_DIV_EN
            quo    <= '0;
            rem    <= '0;
`endif
        end else if (EX_flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_go) begin
                        a_mag <= abs_a;
                        b_mag <= abs_b;
                        sgn_a <= sgn_a_in;
                        sgn_b <= sgn_b_in;
                        op_q  <= ID_EX_md_op[1:0];
                        cnt   <= CNT_W'(W);
`ifdef RISCV_MD_DIV_EN
                        if (ID_EX_md_op[2]) begin
                            if (div_zero || div_ovf) begin
                                state  <= S_DONE;
                                result <= early_res;
                            end else begin
                                state <= S_DIV;
                                quo   <= abs_a;
                                rem   <= '0;
                            end
                        end else begin
`else
                        begin
`endif
                            state <= S_MUL;
                            acc   <= {{W{1'b0}}, abs_b};
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_DONE;
                        result <= (op_q == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
                    end
                end
`ifdef RISCV_MD_DIV_EN
                S_DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_DONE;
                        result <= op_q[1] ? r_fin : q_fin;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign ex_stall = !reset && !EX_flush && (md_go || state == S_MUL || state == S_DIV);

    always_comb begin
        if (!reset && state == S_DONE) alu_out = result;
        else if (ID_EX_md_en)          alu_out = '0;
        else                           alu_out = alu_res;
    end
endmodule

// File: tb/tb_stage_ex_md.sv
// Directed bench for stage_ex_md: ALU/forwarding paths, M-op latency and results via a scoreboard.
module tb_stage_ex_md;
    logic        clk, reset, ID_EX_valid, EX_flush;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] ID_EX_pc, ID_EX_data_out_1, ID_EX_data_out_2, ID_EX_imm_out;
    logic [31:0] WB_data, EX_MEM_alu_out, alu_out, dataB;
    logic [2:0]  ID_EX_alu_sel, ID_EX_md_op;
    logic        ID_EX_ASel, ID_EX_BSel, ID_EX_md_en, ex_stall, ex_illegal;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    stage_ex_md dut (
        .clk(clk), .reset(reset), .ID_EX_valid(ID_EX_valid), .EX_flush(EX_flush),
        .forwardA(forwardA), .forwardB(forwardB), .ID_EX_pc(ID_EX_pc),
        .ID_EX_data_out_1(ID_EX_data_out_1), .ID_EX_data_out_2(ID_EX_data_out_2),
        .ID_EX_imm_out(ID_EX_imm_out), .WB_data(WB_data), .EX_MEM_alu_out(EX_MEM_alu_out),
        .ID_EX_alu_sel(ID_EX_alu_sel), .ID_EX_ASel(ID_EX_ASel), .ID_EX_BSel(ID_EX_BSel),
        .ID_EX_md_en(ID_EX_md_en), .ID_EX_md_op(ID_EX_md_op), .alu_out(alu_out),
        .dataB(dataB), .ex_stall(ex_stall), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference RV32M results straight from 64-bit products and SV division
    function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] x, y, p;
        logic        ovf;
        x   = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
        y   = (op == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = x * y;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'b000:                 return p[31:0];
            3'b001, 3'b010, 3'b011: return p[63:32];
            3'b100:  return (b == 32'h0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'b101:  return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 32'h0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    task automatic set_alu(input logic [2:0] sel);
        ID_EX_md_en = 1'b0; ID_EX_valid = 1'b1; EX_flush = 1'b0;
        ID_EX_ASel = 1'b0; ID_EX_BSel = 1'b0; forwardA = 2'b00; forwardB = 2'b00;
        ID_EX_alu_sel = sel;
    endtask

    // Present an M-op (operands via forwarding, ASel/BSel set to junk), count stall cycles, check result
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stalls);
        int stalls;
        @(posedge clk); #1;
        sb_q.push_back(md_model(op, a, b));
        ID_EX_md_en = 1'b1; ID_EX_valid = 1'b1; EX_flush = 1'b0; ID_EX_md_op = op;
        forwardA = 2'b01; WB_data = a; forwardB = 2'b10; EX_MEM_alu_out = b;
        ID_EX_ASel = 1'b1; ID_EX_BSel = 1'b1; ID_EX_pc = 32'hDEAD_0000; ID_EX_imm_out = 32'h0000_BEEF;
        @(negedge clk);
        check({tag, "_accept_out"}, alu_out, 32'h0);
        check({tag, "_illegal"}, 32'(ex_illegal), 32'h0);
        stalls = 0;
        while (ex_stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            WB_data = $urandom; EX_MEM_alu_out = $urandom;
        end
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
        check({tag, "_result"}, alu_out, sb_q.pop_front());
    endtask

    initial begin
        reset = 1'b1; EX_flush = 1'b0; ID_EX_valid = 1'b1; ID_EX_md_en = 1'b0; ID_EX_md_op = 3'b000;
        forwardA = 2'b00; forwardB = 2'b00; ID_EX_ASel = 1'b0; ID_EX_BSel = 1'b0;
        ID_EX_pc = 32'h0; ID_EX_imm_out = 32'h0; WB_data = 32'h0; EX_MEM_alu_out = 32'h0;
        ID_EX_data_out_1 = 32'd2; ID_EX_data_out_2 = 32'd3; ID_EX_alu_sel = 3'b000;

        // During reset: combinational ALU path, no stall, no illegal
        @(negedge clk);
        check("rst_alu_out", alu_out, 32'd5);
        check("rst_stall", 32'(ex_stall), 32'h0);
        @(posedge clk); #1;
        ID_EX_md_en = 1'b1; ID_EX_md_op = 3'b100;
        @(negedge clk);
        check("rst_md_stall", 32'(ex_stall), 32'h0);
        check("rst_md_illegal", 32'(ex_illegal), 32'h0);
        check("rst_md_out", alu_out, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD with EX/MEM and WB forwarding
        set_alu(3'b000); forwardA = 2'b10; EX_MEM_alu_out = 32'd5; forwardB = 2'b01; WB_data = 32'd7;
        @(negedge clk);
        check("add_fwd_out", alu_out, 32'd12);
        check("add_fwd_dataB", dataB, 32'd7);
        check("add_fwd_stall", 32'(ex_stall), 32'h0);

        // SUB on PC and immediate; dataB stays on the rs2 path
        @(posedge clk); #1;
        set_alu(3'b001); ID_EX_ASel = 1'b1; ID_EX_BSel = 1'b1; ID_EX_pc = 32'h100;
        ID_EX_imm_out = 32'd4; ID_EX_data_out_2 = 32'h55;
        @(negedge clk);
        check("sub_pc_imm_out", alu_out, 32'hFC);
        check("sub_pc_imm_dataB", dataB, 32'h55);

        // Forward select 11 gives zero operands
        @(posedge clk); #1;
        set_alu(3'b000); forwardA = 2'b11; forwardB = 2'b11; ID_EX_data_out_1 = 32'h1234;
        @(negedge clk);
        check("fwd_zero_out", alu_out, 32'h0);
        check("fwd_zero_dataB", dataB, 32'h0);

        // M-op bubble (valid = 0) is not accepted
        @(posedge clk); #1;
        ID_EX_md_en = 1'b1; ID_EX_valid = 1'b0; ID_EX_md_op = 3'b000;
        @(negedge clk);
        check("bubble_stall", 32'(ex_stall), 32'h0);
        check("bubble_out", alu_out, 32'h0);

        // Multiplies, back to back
        run_md("mulh_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 33);
        check("mulh_minmin_spec", alu_out, 32'h4000_0000);
        run_md("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 33);
        run_md("mulhsu_ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_md("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_md("mulh_rand", 3'b001, $urandom, $urandom, 33);

        // Flush at cycle 10 of a MUL
        @(posedge clk); #1;
        set_alu(3'b000); ID_EX_md_en = 1'b1; ID_EX_md_op = 3'b000;
        ID_EX_data_out_1 = 32'd3; ID_EX_data_out_2 = 32'd5;
        for (int c = 0; c < 10; c++) @(posedge clk);
        #1; EX_flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(ex_stall), 32'h0);
        @(posedge clk); #1;
        set_alu(3'b000); ID_EX_data_out_1 = 32'd20; ID_EX_data_out_2 = 32'd22;
        @(negedge clk);
        check("post_flush_stall", 32'(ex_stall), 32'h0);
        check("post_flush_add", alu_out, 32'd42);
        run_md("mul_after_flush", 3'b000, 32'd3, 32'd5, 33);

        // Reset in the middle of a MULHU
        @(posedge clk); #1;
        set_alu(3'b000); ID_EX_md_en = 1'b1; ID_EX_md_op = 3'b011;
        repeat (5) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk);
        check("rst_mid_stall", 32'(ex_stall), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; set_alu(3'b000); ID_EX_data_out_1 = 32'd1; ID_EX_data_out_2 = 32'd2;
        @(negedge clk);
        check("rst_mid_next_stall", 32'(ex_stall), 32'h0);
        check("rst_mid_next_add", alu_out, 32'd3);

`ifdef RISCV_MD_DIV_EN
        run_md("div_neg7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 33);
        check("div_neg7_2_spec", alu_out, 32'hFFFF_FFFD);
        run_md("rem_neg7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 33);
        check("rem_neg7_2_spec", alu_out, 32'hFFFF_FFFF);
        run_md("divu_by0", 3'b101, 32'd100, 32'd0, 1);
        run_md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_md("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_md("remu_100_7", 3'b111, 32'd100, 32'd7, 33);
`else
        // Divider not built: DIV is flagged illegal and never stalls
        @(posedge clk); #1;
        set_alu(3'b000); ID_EX_md_en = 1'b1; ID_EX_md_op = 3'b100;
        ID_EX_data_out_1 = 32'hFFFF_FFF9; ID_EX_data_out_2 = 32'd2;
        @(negedge clk);
        check("nodiv_illegal", 32'(ex_illegal), 32'h1);
        check("nodiv_out", alu_out, 32'h0);
        check("nodiv_stall", 32'(ex_stall), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nodiv_hold_illegal", 32'(ex_illegal), 32'h1);
        check("nodiv_hold_stall", 32'(ex_stall), 32'h0);
        @(posedge clk); #1;
        ID_EX_valid = 1'b0;
        @(negedge clk);
        check("nodiv_invalid_illegal", 32'(ex_illegal), 32'h0);
        run_md("mul_after_nodiv", 3'b000, 32'd6, 32'd7, 33);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
